// File: rtl/l15_wakeup_ctrl.sv
// Tile-level core reset sequencer and IPI delivery for the Ariane tile wrapper.
// Decodes L1.5 interrupt-return packets into WAKE / IPI / SWRST commands.
module l15_wakeup_ctrl #(
  parameter int unsigned InitCycles  = 32768,
  parameter bit          WaitForWake = 1'b0,
  parameter int unsigned SwRstCycles = 16,
  parameter logic [3:0]  IntRetType  = 4'h7,
  parameter int unsigned CntW        =
    $clog2((InitCycles > SwRstCycles) ? InitCycles : SwRstCycles) + 1
) (
  input  logic        clk_i,
  input  logic        reset_l,
  input  logic        l15_val_i,
  input  logic [3:0]  l15_returntype_i,
  input  logic [63:0] l15_data_0_i,
  input  logic        ipi_ack_i,
  output logic        core_rst_no,
  output logic        ipi_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_INIT      = 2'd0,
    ST_WAIT_WAKE = 2'd1,
    ST_RUN       = 2'd2,
    ST_SWRST     = 2'd3
  } state_e;

  localparam logic [CntW-1:0] InitLast  = CntW'(InitCycles - 1);
  localparam logic [CntW-1:0] SwRstLast = CntW'(SwRstCycles - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wake_seen_q, wake_seen_d;
  logic            armed_q;
  logic            ipi_q, ipi_d;
  logic            core_rst_n_q;

  logic       int_pkt;
  logic [1:0] cmd;
  logic       is_wake, is_ipi, is_swrst;
  logic       unused_data;

  assign int_pkt     = l15_val_i && (l15_returntype_i == IntRetType);
  assign cmd         = l15_data_0_i[63:62];
  assign is_wake     = int_pkt && (cmd == 2'b01);
  assign is_ipi      = int_pkt && (cmd == 2'b10);
  assign is_swrst    = int_pkt && (cmd == 2'b11);
  assign unused_data = ^l15_data_0_i[61:0];

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wake_seen_d = wake_seen_q;
    unique case (state_q)
      ST_INIT: begin
        if (is_wake) wake_seen_d = 1'b1;
        // The first released edge only registers the deassertion; counting starts after it.
        if (armed_q) begin
          if (cnt_q == InitLast) begin
            state_d = (WaitForWake && !wake_seen_q && !is_wake) ? ST_WAIT_WAKE : ST_RUN;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      ST_WAIT_WAKE: begin
        if (is_wake) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (is_swrst) state_d = ST_SWRST;
      end
      ST_SWRST: begin
        if (is_swrst) begin
          cnt_d = '0;
        end else if (cnt_q == SwRstLast) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase
    if (state_d != state_q) begin
      cnt_d       = '0;
      wake_seen_d = 1'b0;
    end
  end

  // Set beats ack; anything that leaves or avoids RUN drops the pending IPI.
  always_comb begin
    ipi_d = ipi_q;
    if (is_ipi && (state_q == ST_RUN) && (state_d == ST_RUN)) begin
      ipi_d = 1'b1;
    end else if (ipi_ack_i) begin
      ipi_d = 1'b0;
    end
    if (state_d != ST_RUN) ipi_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge reset_l) begin
    if (!reset_l) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      wake_seen_q  <= 1'b0;
      armed_q      <= 1'b0;
      ipi_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wake_seen_q  <= wake_seen_d;
      armed_q      <= 1'b1;
      ipi_q        <= ipi_d;
      core_rst_n_q <= (state_d == ST_RUN);
    end
  end

  assign core_rst_no = core_rst_n_q;
  assign ipi_o       = ipi_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_l15_wakeup_ctrl.sv
// Self-checking bench: two configurations (WaitForWake 0 and 1) driven with shared
// directed and random packet traffic, compared against a timestamp-based model.
module tb_l15_wakeup_ctrl;

  localparam int INIT = 8;
  localparam int SWR  = 4;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        val = 1'b0;
  logic [3:0]  rtype = 4'h0;
  logic [63:0] data = '0;
  logic        ack = 1'b0;

  logic       rst_n0, ipi0, rst_n1, ipi1;
  logic [1:0] st0, st1;

  always #5 clk = ~clk;

  l15_wakeup_ctrl #(.InitCycles(INIT), .WaitForWake(1'b0), .SwRstCycles(SWR)) u_dut0 (
    .clk_i(clk), .reset_l(reset_l), .l15_val_i(val), .l15_returntype_i(rtype),
    .l15_data_0_i(data), .ipi_ack_i(ack),
    .core_rst_no(rst_n0), .ipi_o(ipi0), .state_o(st0));

  l15_wakeup_ctrl #(.InitCycles(INIT), .WaitForWake(1'b1), .SwRstCycles(SWR)) u_dut1 (
    .clk_i(clk), .reset_l(reset_l), .l15_val_i(val), .l15_returntype_i(rtype),
    .l15_data_0_i(data), .ipi_ack_i(ack),
    .core_rst_no(rst_n1), .ipi_o(ipi1), .state_o(st1));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase per config, release points kept as absolute edge numbers.
  int m_st[2];
  bit m_seen[2];
  bit m_ipi[2];
  int m_rel[2];
  int edge_n;

  task automatic mdl_reset();
    edge_n = 0;
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_seen[i] = 1'b0; m_ipi[i] = 1'b0; m_rel[i] = 0;
    end
  endtask

  task automatic mdl_step();
    bit pkt, wake, ipi, swrst;
    int nx;
    edge_n++;
    pkt   = val && (rtype == 4'h7);
    wake  = pkt && (data[63:62] == 2'b01);
    ipi   = pkt && (data[63:62] == 2'b10);
    swrst = pkt && (data[63:62] == 2'b11);
    for (int i = 0; i < 2; i++) begin
      nx = m_st[i];
      case (m_st[i])
        0: begin
          if (wake) m_seen[i] = 1'b1;
          if (edge_n == INIT + 1) nx = ((i == 1) && !m_seen[i]) ? 1 : 2;
        end
        1: if (wake) nx = 2;
        2: if (swrst) begin nx = 3; m_rel[i] = edge_n + SWR; end
        default: begin
          if (swrst) m_rel[i] = edge_n + SWR;
          else if (edge_n == m_rel[i]) nx = 2;
        end
      endcase
      if (ipi && m_st[i] == 2 && nx == 2) m_ipi[i] = 1'b1;
      else if (ack) m_ipi[i] = 1'b0;
      if (nx != 2) m_ipi[i] = 1'b0;
      m_st[i] = nx;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    mdl_step();
    @(negedge clk);
    check("st0",  st0,    2'(m_st[0]));
    check("rst0", rst_n0, 2'(m_st[0] == 2));
    check("ipi0", ipi0,   2'(m_ipi[0]));
    check("st1",  st1,    2'(m_st[1]));
    check("rst1", rst_n1, 2'(m_st[1] == 2));
    check("ipi1", ipi1,   2'(m_ipi[1]));
  endtask

  task automatic send(input logic v, input logic [3:0] t, input logic [1:0] c, input logic a);
    val = v; rtype = t; data = {c, 30'($urandom), 32'($urandom)}; ack = a;
    cyc();
    val = 1'b0; rtype = 4'h0; data = '0; ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rst0"}, rst_n0, 2'b0);
    check({tag, "_ipi0"}, ipi0,   2'b0);
    check({tag, "_st0"},  st0,    2'd0);
    check({tag, "_rst1"}, rst_n1, 2'b0);
    check({tag, "_ipi1"}, ipi1,   2'b0);
    check({tag, "_st1"},  st1,    2'd0);
  endtask

  // Asserts reset between edges, checks outputs immediately, releases at the next falling edge.
  task automatic async_reset();
    #2 reset_l = 1'b0;
    mdl_reset();
    #1 check_reset_outputs("areset");
    @(negedge clk);
    reset_l = 1'b1;
  endtask

  initial begin
    mdl_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset_l = 1'b1;

    // Basic init: low for 8 samples, high on the 9th.
    for (int k = 1; k <= INIT; k++) begin
      cyc();
      check("init_low", rst_n0, 2'b0);
    end
    cyc();
    check("init_high", rst_n0, 2'b1);
    check("init_run_state", st0, 2'd2);
    check("wait_wake_state", st1, 2'd1);

    // Without a wake the gated config holds in WAIT_WAKE.
    idle(30);
    check("wait_hold", st1, 2'd1);
    send(1'b1, 4'h7, 2'b01, 1'b0);
    check("wake_release", rst_n1, 2'b1);

    // IPI set, ack, set+ack, wrong return type.
    send(1'b1, 4'h7, 2'b10, 1'b0);
    check("ipi_set", ipi0, 2'b1);
    send(1'b0, 4'h0, 2'b00, 1'b1);
    check("ipi_ack", ipi0, 2'b0);
    send(1'b1, 4'h7, 2'b10, 1'b0);
    send(1'b1, 4'h7, 2'b10, 1'b1);
    check("ipi_set_wins", ipi0, 2'b1);
    send(1'b0, 4'h0, 2'b00, 1'b1);
    send(1'b1, 4'h2, 2'b10, 1'b0);
    check("ipi_wrong_type", ipi0, 2'b0);

    // SWRST with IPI pending: 4 low cycles, then back to RUN.
    send(1'b1, 4'h7, 2'b10, 1'b0);
    send(1'b1, 4'h7, 2'b11, 1'b0);
    check("swrst_ipi_clr", ipi0, 2'b0);
    check("swrst_low_1", rst_n0, 2'b0);
    for (int k = 2; k <= SWR; k++) begin
      cyc();
      check("swrst_low", rst_n0, 2'b0);
    end
    cyc();
    check("swrst_high", rst_n0, 2'b1);

    // Restart at hold cycle 2 stretches the low phase to 2+4 cycles.
    send(1'b1, 4'h7, 2'b11, 1'b0);
    cyc();
    send(1'b1, 4'h7, 2'b11, 1'b0);
    for (int k = 1; k <= SWR - 1; k++) begin
      cyc();
      check("swrst_ext_low", rst_n0, 2'b0);
    end
    cyc();
    check("swrst_ext_high", rst_n0, 2'b1);

    // Async reset in the middle of a SWRST hold, then an early WAKE at INIT cycle 3.
    send(1'b1, 4'h7, 2'b11, 1'b0);
    async_reset();
    idle(2);
    send(1'b1, 4'h7, 2'b01, 1'b0);
    for (int k = 4; k <= INIT; k++) begin
      cyc();
      check("early_wake_init", st1, 2'd0);
    end
    cyc();
    check("early_wake_run", st1, 2'd2);
    check("rerun_dut0", rst_n0, 2'b1);

    // Random traffic with occasional async resets.
    for (int n = 0; n < 1200; n++) begin
      logic       v, a;
      logic [3:0] t;
      logic [1:0] c;
      v = 1'($urandom_range(0, 1));
      t = ($urandom_range(0, 3) != 0) ? 4'h7 : 4'($urandom_range(0, 15));
      c = 2'($urandom_range(0, 3));
      if (c == 2'b11 && $urandom_range(0, 3) != 0) c = 2'b10;
      a = ($urandom_range(0, 4) == 0);
      send(v, t, c, a);
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
